// File: rtl/drum_div_pkg.sv
// Shared constants and FSM state type for the DRUM6 48/16 approximate divider.
package drum_div_pkg;

    localparam int K         = 6;
    localparam int FRAC      = 12;
    localparam int QW        = 32;
    localparam int DIV_ITERS = 18;

    localparam logic [QW-1:0] SAT_MAG = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        DIV   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/drum_lod_trunc.sv
// Leading-one detector with DRUM truncation: returns the unbiased 6-bit mantissa
// (leading one, next four bits, forced trailing one) and the scale it was taken at.
module drum_lod_trunc
    import drum_div_pkg::*;
#(
    parameter int W = 48
) (
    input  logic [W-1:0]         x,
    output logic [K-1:0]         mant,
    output logic [$clog2(W)-1:0] shift
);

    localparam int KW = $clog2(W);

    logic [KW-1:0]  lead_s;
    logic [K-3:0]   mid_s;

    // Priority encoder: position of the most significant set bit (0 when x is 0).
    always_comb begin
        lead_s = '0;
        for (int i = 0; i < W; i++) begin
            lead_s = x[i] ? KW'(i) : lead_s;
        end
    end

    // Wide operands keep four bits under the leading one; small ones pass untouched.
    always_comb begin
        mid_s = (K-2)'(x >> (lead_s - KW'(K-2)));
        if (lead_s > KW'(K-1)) begin
            mant  = {1'b1, mid_s, 1'b1};
            shift = lead_s - KW'(K-1);
        end else begin
            mant  = x[K-1:0];
            shift = '0;
        end
    end

endmodule

// File: rtl/drum6_div_48_16.sv
// DRUM6 approximate divider: 48-bit / 16-bit one's-complement operands, truncated
// mantissas divided by an 18-step restoring divider, then rescaled by a barrel shift.
module drum6_div_48_16
    import drum_div_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [47:0]   dividend,
    input  logic [15:0]   divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] quotient,
    output logic          div_by_zero
);

    state_t        state_q;
    logic          in_ready_q, out_valid_q, dbz_out_q;
    logic [QW-1:0] quotient_q;
    logic          sign_q, dbz_q;
    logic [47:0]   a_q;
    logic [15:0]   b_q;
    logic [K-1:0]  nn_q;
    logic [5:0]    p_q;
    logic [3:0]    q_q;
    logic [17:0]   num_q;
    logic [5:0]    rem_q;
    logic [4:0]    cnt_q;

    logic [K-1:0]  mm_s, nn_s;
    logic [5:0]    p_s;
    logic [3:0]    q_s;

    logic [6:0]    rem_sh_s;
    logic          ge_s;
    logic [5:0]    rem_d;
    logic signed [6:0] e_s;
    logic [6:0]    neg_e_s;
    logic [47:0]   mag_wide_s;
    logic [QW-1:0] mag_s, quotient_d;

    drum_lod_trunc #(.W(48)) u_lod_a (.x(a_q), .mant(mm_s), .shift(p_s));
    drum_lod_trunc #(.W(16)) u_lod_b (.x(b_q), .mant(nn_s), .shift(q_s));

    // One restoring-division step: num_q shifts the dividend out and the quotient in.
    always_comb begin
        rem_sh_s = {rem_q, num_q[17]};
        ge_s     = (rem_sh_s >= {1'b0, nn_q});
        if (ge_s) begin
            rem_d = 6'(rem_sh_s - {1'b0, nn_q});
        end else begin
            rem_d = rem_sh_s[5:0];
        end
    end

    // Rescale the mantissa quotient by p - q - FRAC and saturate on overflow or dbz.
    always_comb begin
        e_s        = $signed({1'b0, p_q}) - $signed({3'b000, q_q}) - $signed(7'(FRAC));
        neg_e_s    = 7'(-e_s);
        if (e_s >= 7'sd0) begin
            mag_wide_s = {30'd0, num_q} << e_s;
        end else begin
            mag_wide_s = {30'd0, num_q} >> neg_e_s;
        end
        if (dbz_q || (|mag_wide_s[47:31])) begin
            mag_s = SAT_MAG;
        end else begin
            mag_s = mag_wide_s[31:0];
        end
        quotient_d = sign_q ? ~mag_s : mag_s;
    end

    // Control FSM and all datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dbz_out_q   <= 1'b0;
            quotient_q  <= '0;
            sign_q      <= 1'b0;
            dbz_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            nn_q        <= '0;
            p_q         <= '0;
            q_q         <= '0;
            num_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= dividend[47] ? ~dividend : dividend;
                        b_q        <= divisor[15] ? ~divisor : divisor;
                        sign_q     <= dividend[47] ^ divisor[15];
                        in_ready_q <= 1'b0;
                        state_q    <= PREP;
                    end
                end
                PREP: begin
                    num_q   <= {mm_s, 12'd0};
                    nn_q    <= nn_s;
                    p_q     <= p_s;
                    q_q     <= q_s;
                    dbz_q   <= (b_q == 16'd0);
                    rem_q   <= 6'd0;
                    cnt_q   <= 5'd0;
                    state_q <= DIV;
                end
                DIV: begin
                    num_q <= {num_q[16:0], ge_s};
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(DIV_ITERS - 1)) begin
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    quotient_q  <= quotient_d;
                    dbz_out_q   <= dbz_q;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign div_by_zero = dbz_out_q;

endmodule

// File: doc/drum6_div_48_16.md
Name: drum6_div_48_16

Overview:
- Sequential DRUM-style approximate divider: 48-bit one's-complement dividend / 16-bit one's-complement divisor -> 32-bit one's-complement quotient.
- It is the inverse of the DRUM6 16x32 multiplier and recovers scaled values in the perceptron datapath, e.g. normalising accumulated products.
- Operands are truncated to unbiased 6-bit mantissas, divided by a bit-serial restoring divider and rescaled by a barrel shift.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- K, 6, mantissa width incl. leading one and forced trailing one.
- FRAC, 12, extra fraction bits produced by the mantissa division.
- QW, 32, quotient width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- dividend  input  48  one's-complement; bit 47 is the sign.
- divisor  input  16  one's-complement; bit 15 is the sign.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- quotient  output  32  one's-complement approximate quotient.
- div_by_zero  output  1  divisor magnitude was zero; valid with out_valid.

Behaviour:
- Reset, asynchronous: state=IDLE, in_ready=1, out_valid=0, quotient=0, div_by_zero=0, all internal registers 0. Reset mid-operation abandons the operation; no output is produced for it.
- States: IDLE -> PREP -> DIV -> SHIFT -> DONE -> IDLE.
- in_ready=1 only in IDLE. Acceptance = in_valid & in_ready at edge T. Operands are registered; sign = dividend[47]^divisor[15]. Magnitudes: ~x if the sign bit is set, else x.
- PREP (1 cycle):
  - LOD + priority encode give ka (0..47) and kb (0..15).
  - If ka>5: mm={1,a[ka-1:ka-4],1}, p=ka-5; else mm=a[5:0], p=0. Same rule for divisor gives nn and q.
  - Divisor magnitude 0 sets the dbz flag. 0xFFFF is negative zero and also counts as zero.
- DIV (18 cycles): restoring division of {mm,12'b0} (18 bits) by nn, one quotient bit per cycle, MSB first. Result Qm is 18 bits. With dbz set, the cycles still elapse and the result is ignored.
- SHIFT (1 cycle):
  - e = p - q - FRAC, 7-bit signed, range -22..30.
  - e>=0: mag=Qm<<e. e<0: mag=Qm>>(-e), truncating.
  - mag>0x7FFFFFFF or dbz: mag=0x7FFFFFFF.
  - quotient = sign ? ~mag : mag, registered.
- DONE: out_valid asserts at edge T+20. quotient and div_by_zero hold stable while out_ready=0. On out_valid & out_ready: next edge clears out_valid and returns to IDLE with in_ready=1. No acceptance overlaps DONE.
- Dividend magnitude 0 gives quotient 0 (or 0xFFFFFFFF if the sign bit is set), dbz=0.
- Operands with magnitude <=63 go through untruncated. The result is then exact to floor, within the FRAC precision.

Decomposition:
- Package drum_div_pkg holds:
  - K, FRAC, QW;
  - SAT_MAG=32'h7FFF_FFFF;
  - state enum {IDLE, PREP, DIV, SHIFT, DONE};
  - the DIV iteration count 18.
- Sub-module drum_lod_trunc, parameterised by width W: combinational LOD + encoder + 6-bit mantissa/shift extraction. It is instantiated twice (W=48, W=16).

Test Plan:
- dividend=60, divisor=5 -> quotient=12 (0x0000000C), div_by_zero=0, out_valid exactly 20 cycles after acceptance.
- dividend=1000000, divisor=1000 -> mm=61, p=14, nn=63, q=4, Qm=3965, e=-2 -> quotient=991.
- dividend=~60 (0xFFFFFFFFFFC3), divisor=5 -> quotient=0xFFFFFFF3. Separately, dividend=60, divisor=0xFFFF -> div_by_zero=1, quotient=0x80000000.
- dividend=0x400000000000, divisor=1 -> e=29 overflow -> quotient=0x7FFFFFFF, div_by_zero=0. Separately, dividend=7, divisor=0 -> quotient=0x7FFFFFFF, div_by_zero=1.
- Hold out_ready=0 for 5 cycles after out_valid -> quotient stable and in_ready=0 throughout. in_valid pulsed during that window is not accepted. A handshake on cycle 6 gives in_ready=1 on the next cycle.
- Assert rst asynchronously mid-DIV (cycle 10) -> outputs at reset values immediately. After release, a new 60/5 operation returns 12 with normal latency.
